// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART oversampling constants and transmitter state type
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_CNT_W = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serializer with one-entry holding register; UART_TX_PARITY_EN adds even parity
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = 32,
    parameter int STP_BITS_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_tx_done
);

    // The tick counter also times the stop period, which may exceed one bit.
    localparam int W_TICK = (STP_BITS_TICKS > OVERSAMPLE) ? $clog2(STP_BITS_TICKS) : TICK_CNT_W;
    localparam int W_BIT  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [W_TICK-1:0] BIT_LAST_TICK  = W_TICK'(OVERSAMPLE - 1);
    localparam logic [W_TICK-1:0] STOP_LAST_TICK = W_TICK'(STP_BITS_TICKS - 1);
    localparam logic [W_BIT-1:0]  LAST_BIT       = W_BIT'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_next_state;
    logic [W_TICK-1:0]    r_tick_cnt;
    logic [W_TICK-1:0]    w_next_tick_cnt;
    logic [W_BIT-1:0]     r_bit_cnt;
    logic [W_BIT-1:0]     w_next_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_next_shift;
    logic [DATA_BITS-1:0] w_shifted;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic                 r_tx;
    logic                 w_next_tx;
    logic                 r_tx_done;
    logic                 w_next_tx_done;
    logic                 w_load;
    logic                 w_accept;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    assign w_accept   = i_tx_start && !r_hold_full;
    assign w_shifted  = r_shift >> 1;
    assign o_tx_ready = !r_hold_full;
    assign o_tx       = r_tx;
    assign o_tx_done  = r_tx_done;

    always_comb begin
        w_next_state    = r_state;
        w_next_tick_cnt = r_tick_cnt;
        w_next_bit_cnt  = r_bit_cnt;
        w_next_shift    = r_shift;
        w_next_tx       = r_tx;
        w_next_tx_done  = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_tx = 1'b1;
                if (r_hold_full) begin
                    w_load = 1'b1;
                end
            end

            START: begin
                if (i_bd_tick) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_next_state    = DATA;
                        w_next_tick_cnt = '0;
                        w_next_bit_cnt  = '0;
                        w_next_tx       = r_shift[0];
                    end else begin
                        w_next_tick_cnt = r_tick_cnt + W_TICK'(1);
                    end
                end
            end

            DATA: begin
                if (i_bd_tick) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_next_tick_cnt = '0;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            w_next_state = PARITY;
                            w_next_tx    = r_parity;
`else
                            w_next_state = STOP;
                            w_next_tx    = 1'b1;
`endif
                        end else begin
                            w_next_shift   = w_shifted;
                            w_next_bit_cnt = r_bit_cnt + W_BIT'(1);
                            w_next_tx      = w_shifted[0];
                        end
                    end else begin
                        w_next_tick_cnt = r_tick_cnt + W_TICK'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (i_bd_tick) begin
                    if (r_tick_cnt == BIT_LAST_TICK) begin
                        w_next_state    = STOP;
                        w_next_tick_cnt = '0;
                        w_next_tx       = 1'b1;
                    end else begin
                        w_next_tick_cnt = r_tick_cnt + W_TICK'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (i_bd_tick) begin
                    if (r_tick_cnt == STOP_LAST_TICK) begin
                        w_next_tx_done  = 1'b1;
                        w_next_tick_cnt = '0;
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_next_state = IDLE;
                            w_next_tx    = 1'b1;
                        end
                    end else begin
                        w_next_tick_cnt = r_tick_cnt + W_TICK'(1);
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
                w_next_tx    = 1'b1;
            end
        endcase

        // Loading from IDLE or straight out of STOP both start a fresh frame.
        if (w_load) begin
            w_next_state    = START;
            w_next_tick_cnt = '0;
            w_next_bit_cnt  = '0;
            w_next_shift    = r_hold;
            w_next_tx       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tick_cnt <= w_next_tick_cnt;
            r_bit_cnt  <= w_next_bit_cnt;
            r_shift    <= w_next_shift;
            r_tx       <= w_next_tx;
            r_tx_done  <= w_next_tx_done;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= i_data;
            r_hold_full <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^r_hold;
        end
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter; honours UART_TX_PARITY_EN
module tb_uart_transmitter;

    localparam int DB  = 32;
    localparam int STP = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME    = 16 + 16 * DB + 16 * PAR_BITS + STP;
    localparam int STOP_IDX = 1 + DB + PAR_BITS;

    logic          clk        = 1'b0;
    logic          i_reset    = 1'b1;
    logic          i_bd_tick  = 1'b1;
    logic          i_tx_start = 1'b0;
    logic [DB-1:0] i_data     = '0;
    logic          o_tx_ready;
    logic          o_tx;
    logic          o_tx_done;

    uart_transmitter #(
        .DATA_BITS      (DB),
        .STP_BITS_TICKS (STP)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_bd_tick  (i_bd_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx_ready (o_tx_ready),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DB-1:0] sb[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Line decoder: counts DUT ticks and samples o_tx mid-bit.
    int            g_ticks     = 0;
    int            cur_start   = 0;
    int            done_cnt    = 0;
    int            done_t_prev = 0;
    int            done_t_last = 0;
    int            frames_rx   = 0;
    int            dec_k       = 0;
    int            idx         = 0;
    logic          prev_tick   = 1'b0;
    logic          dec_active  = 1'b0;
    logic          dec_par     = 1'b0;
    logic [DB-1:0] dec_word    = '0;
    logic [DB-1:0] exp_w;

    always @(negedge clk) begin
        logic ticked;
        ticked    = prev_tick;
        prev_tick = i_bd_tick;
        if (ticked) g_ticks++;
        if (i_reset) begin
            dec_active = 1'b0;
            sb.delete();
        end else begin
            if (o_tx_done) begin
                done_cnt++;
                done_t_prev = done_t_last;
                done_t_last = g_ticks;
                check("done_frame_len", g_ticks - cur_start, FRAME);
            end
            if (dec_active) begin
                if (ticked) begin
                    dec_k++;
                    if (dec_k % 16 == 8) begin
                        idx = dec_k / 16;
                        if (idx == 0) begin
                            check("start_bit", o_tx, 1'b0);
                        end else if (idx <= DB) begin
                            dec_word[idx-1] = o_tx;
                        end else if (idx < STOP_IDX) begin
                            dec_par = o_tx;
                        end else begin
                            check("stop_bit", o_tx, 1'b1);
                            if (sb.size() == 0) begin
                                check("sb_underflow", 1, 0);
                            end else begin
                                exp_w = sb.pop_front();
                                check("rx_word", dec_word, exp_w);
`ifdef UART_TX_PARITY_EN
                                check("rx_parity", dec_par, ^exp_w);
`endif
                            end
                            frames_rx++;
                            dec_active = 1'b0;
                        end
                    end
                end
            end else if (o_tx == 1'b0) begin
                dec_active = 1'b1;
                dec_k      = 0;
                cur_start  = g_ticks;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DB-1:0] w, input logic exp_acc);
        check("offer_ready", o_tx_ready, exp_acc);
        i_tx_start = 1'b1;
        i_data     = w;
        step();
        i_tx_start = 1'b0;
        i_data     = DB'($urandom);
        if (exp_acc) sb.push_back(w);
    endtask

    task automatic wait_done(input int budget, output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (n < budget && !found) begin
            step();
            n++;
            if (o_tx_done) found = 1'b1;
        end
        check("done_seen", found, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   bad;
        int   d0;
        int   f0;
        logic tx0;

        repeat (3) step();
        check("rst_tx", o_tx, 1'b1);
        check("rst_ready", o_tx_ready, 1'b1);
        check("rst_done", o_tx_done, 1'b0);
        i_reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            step();
            if (o_tx !== 1'b1 || o_tx_ready !== 1'b1 || o_tx_done !== 1'b0) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        // Single frame and its start latency
        offer(32'hA5C3_0F01, 1'b1);
        check("ready_after_accept", o_tx_ready, 1'b0);
        check("tx_idle_n1", o_tx, 1'b1);
        step();
        check("tx_low_n2", o_tx, 1'b0);
        check("ready_after_load", o_tx_ready, 1'b1);
        wait_done(FRAME + 50, n);
        check("done_latency", n, FRAME);
        step();
        check("done_single_pulse", o_tx_done, 1'b0);
        check("frames_single", frames_rx, 1);

        // Back-to-back frames; third offer must be ignored
        repeat (20) step();
        d0 = done_cnt;
        f0 = frames_rx;
        offer(32'h0000_0001, 1'b1);
        repeat (100) step();
        offer(32'hFFFF_FFFF, 1'b1);
        check("ready_hold_full", o_tx_ready, 1'b0);
        repeat (10) step();
        offer(32'h1234_5678, 1'b0);
        wait_done(FRAME + 50, n);
        check("b2b_no_gap", o_tx, 1'b0);
        check("b2b_ready_after_load", o_tx_ready, 1'b1);
        wait_done(FRAME + 50, n);
        check("b2b_second_latency", n, FRAME);
        repeat (FRAME + 50) step();
        check("b2b_done_spacing", done_t_last - done_t_prev, FRAME);
        check("b2b_done_count", done_cnt - d0, 2);
        check("b2b_frames", frames_rx - f0, 2);

        // Accept on the same edge as stop completion gives a one-clock idle gap
        offer(32'h0F0F_1234, 1'b1);
        repeat (FRAME) step();
        offer(32'h8000_0001, 1'b1);
        check("gap_done", o_tx_done, 1'b1);
        check("gap_tx_high", o_tx, 1'b1);
        check("gap_ready", o_tx_ready, 1'b0);
        step();
        check("gap_start_low", o_tx, 1'b0);
        wait_done(FRAME + 50, n);
        check("gap_frame_latency", n, FRAME);
        repeat (30) step();

        // Ticks withheld: line frozen, accept still possible
        offer(32'h3C3C_5A5A, 1'b1);
        repeat (100) step();
        i_bd_tick = 1'b0;
        tx0 = o_tx;
        bad = 0;
        offer(32'h00FF_00FF, 1'b1);
        repeat (40) begin
            step();
            if (o_tx !== tx0 || o_tx_done !== 1'b0) bad++;
        end
        check("freeze_bad", bad, 0);
        check("freeze_ready", o_tx_ready, 1'b0);
        i_bd_tick = 1'b1;
        wait_done(FRAME + 100, n);
        wait_done(FRAME + 50, n);
        check("post_freeze_latency", n, FRAME);
        repeat (30) step();

        // Reset 200 ticks into a frame with a word waiting
        d0 = done_cnt;
        f0 = frames_rx;
        offer(32'hDEAD_BEEF, 1'b1);
        step();
        check("midrst_frame_started", o_tx, 1'b0);
        repeat (199) step();
        offer(32'hCAFE_F00D, 1'b1);
        i_reset = 1'b1;
        step();
        check("midrst_tx", o_tx, 1'b1);
        check("midrst_ready", o_tx_ready, 1'b1);
        check("midrst_done", o_tx_done, 1'b0);
        i_reset = 1'b0;
        bad = 0;
        repeat (FRAME + 100) begin
            step();
            if (o_tx !== 1'b1 || o_tx_done !== 1'b0) bad++;
        end
        check("midrst_line_idle", bad, 0);
        check("midrst_no_frames", frames_rx - f0, 0);
        check("midrst_no_done", done_cnt - d0, 0);

`ifdef UART_TX_PARITY_EN
        offer(32'h0000_0007, 1'b1);
        step();
        wait_done(FRAME + 50, n);
        check("par7_latency", n, FRAME);
        repeat (10) step();
        offer(32'h0000_0003, 1'b1);
        step();
        wait_done(FRAME + 50, n);
        check("par3_latency", n, FRAME);
`endif

        repeat (20) step();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
